// File: rtl/eb2a_ctrl.sv
// Handshake controller for the two-register elastic buffer: turns t_0/i_0 req/ack
// into load enables and an output select, plus occupancy and debug counters.
module eb2a_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 t_0_req,
  output logic                 t_0_ack,
  output logic                 i_0_req,
  input  logic                 i_0_ack,
  output logic                 en0,
  output logic                 en1,
  output logic                 sel,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] xfer_in_cnt,
  output logic [CNT_WIDTH-1:0] xfer_out_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 wr_ptr_q, rd_ptr_q;
  logic                 t_0_ack_q, i_0_req_q;
  logic [1:0]           occ_q;
  logic [CNT_WIDTH-1:0] in_cnt_q, out_cnt_q, stall_cnt_q;
  logic                 push, pop, stall;

  // Acks come from registers only, so req/ack never forms a combinational loop across stages.
  assign push  = t_0_req & t_0_ack_q;
  assign pop   = i_0_req_q & i_0_ack;
  assign stall = t_0_req & ~t_0_ack_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push & ~pop)      state_d = FULL;
        else if (pop & ~push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      t_0_ack_q   <= 1'b1;
      i_0_req_q   <= 1'b0;
      occ_q       <= 2'd0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      t_0_ack_q <= (state_d != FULL);
      i_0_req_q <= (state_d != EMPTY);
      occ_q     <= (state_d == FULL) ? 2'd2 : ((state_d == ONE) ? 2'd1 : 2'd0);
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
        in_cnt_q <= in_cnt_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        out_cnt_q <= out_cnt_q + 1'b1;
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // Reset gates the enables so the datapath never loads while the buffer is being cleared.
  assign en0          = push & ~wr_ptr_q & ~reset;
  assign en1          = push &  wr_ptr_q & ~reset;
  assign t_0_ack      = t_0_ack_q;
  assign i_0_req      = i_0_req_q;
  assign sel          = rd_ptr_q;
  assign occupancy    = occ_q;
  assign xfer_in_cnt  = in_cnt_q;
  assign xfer_out_cnt = out_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
